// File: rtl/uart_scroll_row_pkg.sv
// Shared ASCII constants and byte classification for the text-engine row sources.
// The edit decoder turns a received byte plus the current write position into one edit kind.
package uart_scroll_row_pkg;

  localparam logic [7:0] ASCII_SPACE     = 8'h20;
  localparam logic [7:0] ASCII_BS        = 8'h08;
  localparam logic [7:0] ASCII_DEL       = 8'h7F;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    EDIT_NONE,
    EDIT_PUT,
    EDIT_BACK,
    EDIT_CLEAR
  } edit_e;

  // Backspace at column 0 and LF decode to EDIT_NONE so they never restart the cursor blink.
  function automatic edit_e decode_byte(input logic [7:0] b, input logic [4:0] pos);
    edit_e e;
    e = EDIT_NONE;
    if (b >= ASCII_PRINT_MIN && b <= ASCII_PRINT_MAX) begin
      e = EDIT_PUT;
    end else if ((b == ASCII_BS || b == ASCII_DEL) && pos != 5'd0) begin
      e = EDIT_BACK;
    end else if (b == ASCII_CR) begin
      e = EDIT_CLEAR;
    end else if (b == ASCII_LF) begin
      e = EDIT_NONE;
    end
    return e;
  endfunction

endpackage

// File: rtl/uart_scroll_row_cursor_blink.sv
// Cursor phase generator: toggles every BLINK_TICKS cycles, held visible while restart pulses.
// A restart landing in the wrap cycle takes priority over the toggle.
module cursor_blink #(
  parameter int BLINK_TICKS = 13500000
) (
  input  logic i_clk,
  input  logic i_resetN,
  input  logic i_restart,
  output logic o_cursorOn
);

  localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0] r_blinkCnt;
  logic          r_cursorOn;

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_blinkCnt <= '0;
      r_cursorOn <= 1'b1;
    end else if (i_restart) begin
      r_blinkCnt <= '0;
      r_cursorOn <= 1'b1;
    end else if (r_blinkCnt == CW'(BLINK_TICKS - 1)) begin
      r_blinkCnt <= '0;
      r_cursorOn <= ~r_cursorOn;
    end else begin
      r_blinkCnt <= r_blinkCnt + CW'(1);
    end
  end

  assign o_cursorOn = r_cursorOn;

endmodule

// File: rtl/uart_scroll_row.sv
// 16-column editable text row fed by UART bytes, with backspace, CR clear, left scroll on
// overflow and a blinking cursor; serves charIndex -> charOut with one cycle of latency.
module uart_scroll_row
  import uart_scroll_row_pkg::*;
#(
  parameter int         ROW_LENGTH  = 16,
  parameter int         BLINK_TICKS = 13500000,
  parameter logic [7:0] CURSOR_CHAR = 8'h5F
) (
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic       i_byteReady,
  input  logic [7:0] i_dataIn,
  input  logic [3:0] i_charIndex,
  output logic [7:0] o_charOut,
  output logic [4:0] o_charCount
);

  logic       r_readyPrev;
  logic [7:0] r_buf [ROW_LENGTH];
  logic [4:0] r_writePos;
  logic [7:0] r_charOut;

  logic       w_event;
  edit_e      w_edit;
  logic       w_restart;
  logic       w_cursorOn;
  logic [3:0] w_prevCol;

  assign w_event   = i_byteReady & ~r_readyPrev;
  assign w_edit    = w_event ? decode_byte(i_dataIn, r_writePos) : EDIT_NONE;
  assign w_restart = (w_edit != EDIT_NONE);
  assign w_prevCol = r_writePos[3:0] - 4'd1;

  cursor_blink #(
    .BLINK_TICKS(BLINK_TICKS)
  ) u_cursor_blink (
    .i_clk      (i_clk),
    .i_resetN   (i_resetN),
    .i_restart  (w_restart),
    .o_cursorOn (w_cursorOn)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      // readyPrev starts high so a level already asserted at release is not a new byte
      r_readyPrev <= 1'b1;
      r_writePos  <= 5'd0;
      r_charOut   <= ASCII_SPACE;
      for (int i = 0; i < ROW_LENGTH; i++) r_buf[i] <= ASCII_SPACE;
    end else begin
      r_readyPrev <= i_byteReady;
      r_charOut   <= (w_cursorOn && !r_writePos[4] && i_charIndex == r_writePos[3:0])
                     ? CURSOR_CHAR : r_buf[i_charIndex];
      case (w_edit)
        EDIT_PUT: begin
          if (r_writePos[4]) begin
            for (int i = 0; i < ROW_LENGTH - 1; i++) r_buf[i] <= r_buf[i+1];
            r_buf[ROW_LENGTH-1] <= i_dataIn;
          end else begin
            r_buf[r_writePos[3:0]] <= i_dataIn;
            r_writePos             <= r_writePos + 5'd1;
          end
        end
        EDIT_BACK: begin
          r_buf[w_prevCol] <= ASCII_SPACE;
          r_writePos       <= r_writePos - 5'd1;
        end
        EDIT_CLEAR: begin
          for (int i = 0; i < ROW_LENGTH; i++) r_buf[i] <= ASCII_SPACE;
          r_writePos <= 5'd0;
        end
        default: ;
      endcase
    end
  end

  assign o_charOut   = r_charOut;
  assign o_charCount = r_writePos;

endmodule

// File: tb/tb_uart_scroll_row.sv
// Directed bench for uart_scroll_row with a short blink period: table-driven row reads
// plus hand-written sequences for reset, edge detection and blink/edit timing.
module tb_uart_scroll_row;

  logic       clk = 1'b0;
  logic       resetN;
  logic       byteReady;
  logic [7:0] dataIn;
  logic [3:0] charIndex;
  logic [7:0] charOut;
  logic [4:0] charCount;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vecs[$];

  always #5 clk = ~clk;

  uart_scroll_row #(
    .ROW_LENGTH  (16),
    .BLINK_TICKS (8),
    .CURSOR_CHAR (8'h5F)
  ) dut (
    .i_clk       (clk),
    .i_resetN    (resetN),
    .i_byteReady (byteReady),
    .i_dataIn    (dataIn),
    .i_charIndex (charIndex),
    .o_charOut   (charOut),
    .o_charCount (charCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic do_reset();
    resetN    = 1'b0;
    byteReady = 1'b0;
    tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic send(input logic [7:0] b);
    byteReady = 1'b1;
    dataIn    = b;
    tick();
    byteReady = 1'b0;
    tick();
  endtask

  task automatic add_rd(input logic [3:0] idx, input logic [7:0] exp);
    rd_vec_t v;
    v.idx = idx;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic run_reads(input string tag);
    foreach (vecs[k]) begin
      charIndex = vecs[k].idx;
      tick();
      check8($sformatf("%s idx%0d", tag, vecs[k].idx), charOut, vecs[k].exp);
    end
    vecs.delete();
  endtask

  initial begin
    string s;
    resetN    = 1'b0;
    byteReady = 1'b0;
    dataIn    = 8'h00;
    charIndex = 4'd0;

    // Reset values
    tick();
    check8("reset charOut", charOut, 8'h20);
    check8("reset charCount", {3'b0, charCount}, 8'd0);

    // Test 1: "HI", with the edit cycle returning pre-edit contents
    do_reset();
    charIndex = 4'd0;
    byteReady = 1'b1;
    dataIn    = "H";
    tick();
    check8("t1 pre-edit read", charOut, 8'h5F);
    byteReady = 1'b0;
    tick();
    send("I");
    add_rd(4'd0, "H");
    add_rd(4'd1, "I");
    add_rd(4'd2, 8'h5F);
    add_rd(4'd3, 8'h20);
    run_reads("t1");
    check8("t1 charCount", {3'b0, charCount}, 8'd2);

    // Test 2: 17 chars scroll left by one, row full so no cursor
    do_reset();
    s = "ABCDEFGHIJKLMNOPQ";
    for (int i = 0; i < 17; i++) send(s[i]);
    for (int i = 0; i < 16; i++) add_rd(4'(i), 8'(8'd66 + i));
    run_reads("t2");
    check8("t2 charCount", {3'b0, charCount}, 8'd16);

    // Test 3: backspaces, the third at column 0 is ignored and does not restart the blink
    do_reset();
    send("A");
    send("B");
    send(8'h08);
    send(8'h08);
    send(8'h7F);
    check8("t3 charCount", {3'b0, charCount}, 8'd0);
    add_rd(4'd0, 8'h5F);
    add_rd(4'd1, 8'h20);
    run_reads("t3");
    charIndex = 4'd0;
    repeat (5) tick();
    check8("t3 idx0 cursor off", charOut, 8'h20);

    // Test 4: CR clears once, LF ignored
    do_reset();
    send("X");
    send("Y");
    send("Z");
    send(8'h0D);
    send(8'h0A);
    add_rd(4'd0, 8'h5F);
    for (int i = 1; i < 16; i++) add_rd(4'(i), 8'h20);
    run_reads("t4");
    check8("t4 charCount", {3'b0, charCount}, 8'd0);

    // Test 5: byteReady high through reset release is not a byte
    dataIn    = "Z";
    resetN    = 1'b0;
    byteReady = 1'b1;
    tick();
    resetN = 1'b1;
    repeat (3) tick();
    check8("t5 held-high no edit", {3'b0, charCount}, 8'd0);
    byteReady = 1'b0;
    tick();
    dataIn    = "K";
    byteReady = 1'b1;
    repeat (4) tick();
    byteReady = 1'b0;
    tick();
    check8("t5 one K charCount", {3'b0, charCount}, 8'd1);
    add_rd(4'd0, "K");
    add_rd(4'd1, 8'h5F);
    run_reads("t5");

    // Test 6a: idle blink toggles after 8 cycles
    do_reset();
    charIndex = 4'd0;
    repeat (7) tick();
    check8("t6 cursor before wrap", charOut, 8'h5F);
    tick();
    check8("t6 cursor after wrap", charOut, 8'h20);

    // Test 6b: an edit in the wrap cycle keeps the cursor on and restarts the count
    do_reset();
    repeat (6) tick();
    byteReady = 1'b1;
    dataIn    = "W";
    tick();
    byteReady = 1'b0;
    charIndex = 4'd1;
    tick();
    check8("t6 edit wins wrap", charOut, 8'h5F);
    repeat (7) tick();
    check8("t6 cursor held 8 cycles", charOut, 8'h5F);
    tick();
    check8("t6 cursor off after restart", charOut, 8'h20);
    charIndex = 4'd0;
    tick();
    check8("t6 W stored", charOut, "W");

    // Test 6c: reset mid-row
    send("M");
    resetN = 1'b0;
    tick();
    check8("t6 mid reset charOut", charOut, 8'h20);
    check8("t6 mid reset charCount", {3'b0, charCount}, 8'd0);
    resetN = 1'b1;
    add_rd(4'd0, 8'h5F);
    add_rd(4'd1, 8'h20);
    run_reads("t6 post reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
